// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage
package fetch_pkg;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  typedef enum logic [1:0] {RUN, WAIT, FLUSH} fetch_state_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: 2-entry circular buffer of fetched instructions with their PCs
module fetch_queue import fetch_pkg::*; (
  input  logic         req,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         clear,
  output fetch_entry_t head,
  output logic [1:0]   count
);
  fetch_entry_t mem_q [2];
  fetch_entry_t mem_d [2];
  logic rd_q, rd_d, wr_q, wr_d, do_pop;
  logic [1:0] count_q, count_d;
  always_comb begin
    do_pop = pop && count_q != 2'd0;
    mem_d = mem_q;
    if (push) mem_d[wr_q] = push_entry;
    rd_d = clear ? 1'b0 : rd_q ^ do_pop;
    wr_d = clear ? 1'b0 : wr_q ^ push;
    count_d = clear ? 2'd0 : count_q + {1'b0, push} - {1'b0, do_pop};
  end
  always_ff @(posedge req) begin
    if (!reset) begin
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      count_q <= 2'd0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
      count_q <= count_d;
      mem_q <= mem_d;
    end
  end
  assign head = mem_q[rd_q];
  assign count = count_q;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC/request FSM feeding a 2-entry instruction queue toward decode
module fetch_stage import fetch_pkg::*; #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        req,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        valid_out,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out
);
  fetch_state_t state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d, pending_pc_q, pending_pc_d;
  logic accept, push, pop;
  logic [1:0] count;
  fetch_entry_t head, push_entry;
  always_comb begin
    imem_req_valid = reset && state_q == RUN && count != 2'd2 && !redirect;
    accept = imem_req_valid && imem_req_ready;
    push = state_q == WAIT && imem_resp_valid && !redirect;
    pop = valid_out && !stall;
    pending_pc_d = accept ? fetch_pc_q : pending_pc_q;
    fetch_pc_d = redirect ? {redirect_pc[31:2], 2'b00} : accept ? fetch_pc_q + 32'd4 : fetch_pc_q;
    state_d = redirect ? ((state_q != RUN && !imem_resp_valid) ? FLUSH : RUN)
            : accept ? WAIT
            : (state_q != RUN && imem_resp_valid) ? RUN : state_q;
  end
  always_ff @(posedge req) begin
    if (!reset) begin
      state_q <= RUN;
      fetch_pc_q <= RESET_PC;
      pending_pc_q <= RESET_PC;
    end else begin
      state_q <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pending_pc_q <= pending_pc_d;
    end
  end
  assign push_entry = '{pc: pending_pc_q, instr: imem_resp_data};
  fetch_queue u_queue (
    .req       (req),
    .reset     (reset),
    .push      (push),
    .push_entry(push_entry),
    .pop       (pop),
    .clear     (redirect),
    .head      (head),
    .count     (count)
  );
  assign imem_addr = fetch_pc_q;
  assign valid_out = count != 2'd0;
  assign instr_out = valid_out ? head.instr : NOP_INSTR;
  assign pc_out = valid_out ? head.pc : 32'h0;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: randomized fetch traffic checked against a queue-based reference model
module tb_fetch_stage;
  logic req = 1'b0;
  logic reset, stall, redirect, ready, resp_valid;
  logic [31:0] redirect_pc, resp_data;
  logic imem_req_valid, valid_out;
  logic [31:0] imem_addr, instr_out, pc_out;
  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] m_q [$];
  logic [31:0] m_pc, m_pend;
  bit m_out, m_sq;
  bit mem_busy;
  logic [31:0] mem_addr;
  int mem_dly;
  fetch_stage dut (
    .req            (req),
    .reset          (reset),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_addr      (imem_addr),
    .imem_req_ready (ready),
    .imem_resp_valid(resp_valid),
    .imem_resp_data (resp_data),
    .valid_out      (valid_out),
    .instr_out      (instr_out),
    .pc_out         (pc_out)
  );
  always #5 req = ~req;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] pick_target();
    case ($urandom_range(3))
      0: return 32'h0000_0100;
      1: return 32'h0000_0103;
      2: return 32'hFFFF_FFF9;
      default: return $urandom;
    endcase
  endfunction
  task automatic run(input int cycles, input int ps, input int pr, input int pnr, input int prst, input int md);
    bit exp_rv, dut_acc;
    for (int i = 0; i < cycles; i++) begin
      @(negedge req);
      reset = $urandom_range(99) < prst ? 1'b0 : 1'b1;
      stall = $urandom_range(99) < ps;
      redirect = $urandom_range(99) < pr;
      redirect_pc = pick_target();
      ready = !($urandom_range(99) < pnr);
      resp_valid = mem_busy && mem_dly == 0;
      resp_data = resp_valid ? mem_addr ^ 32'hA5A5_0000 : $urandom;
      #1;
      exp_rv = reset && !m_out && m_q.size() < 2 && !redirect;
      check("req_valid", imem_req_valid, exp_rv);
      if (exp_rv) check("imem_addr", imem_addr, m_pc);
      check("valid_out", valid_out, m_q.size() != 0);
      check("instr_out", instr_out, m_q.size() != 0 ? m_q[0][31:0] : 32'h0000_0013);
      check("pc_out", pc_out, m_q.size() != 0 ? m_q[0][63:32] : 32'h0);
      dut_acc = imem_req_valid && ready;
      if (!reset) begin
        m_q.delete();
        m_pc = 32'h0;
        m_out = 0;
        m_sq = 0;
      end else if (redirect) begin
        m_q.delete();
        m_pc = redirect_pc & ~32'h3;
        if (m_out && resp_valid) begin
          m_out = 0;
          m_sq = 0;
        end else if (m_out) m_sq = 1;
      end else begin
        if (m_q.size() != 0 && !stall) void'(m_q.pop_front());
        if (m_out && resp_valid) begin
          if (!m_sq) m_q.push_back({m_pend, m_pend ^ 32'hA5A5_0000});
          m_out = 0;
          m_sq = 0;
        end
        if (exp_rv && ready) begin
          m_out = 1;
          m_pend = m_pc;
          m_pc = m_pc + 32'd4;
        end
      end
      if (!reset) mem_busy = 0;
      else begin
        if (resp_valid) mem_busy = 0;
        else if (mem_busy) mem_dly--;
        if (dut_acc) begin
          mem_busy = 1;
          mem_addr = imem_addr;
          mem_dly = $urandom_range(md);
        end
      end
    end
  endtask
  initial begin
    reset = 1'b0;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    ready = 1'b1;
    resp_valid = 1'b0;
    resp_data = 32'h0;
    repeat (2) @(posedge req);
    @(negedge req);
    check("rst_req_valid", imem_req_valid, 32'h0);
    check("rst_valid_out", valid_out, 32'h0);
    check("rst_instr_out", instr_out, 32'h0000_0013);
    check("rst_pc_out", pc_out, 32'h0);
    m_pc = 32'h0;
    m_pend = 32'h0;
    m_out = 0;
    m_sq = 0;
    mem_busy = 0;
    mem_addr = 32'h0;
    mem_dly = 0;
    run(20, 0, 0, 0, 0, 0);
    run(150, 70, 0, 0, 0, 1);
    run(200, 20, 8, 0, 0, 2);
    run(200, 20, 5, 50, 0, 2);
    run(400, 30, 8, 30, 2, 3);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
